// File: rtl/denise_hamencoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : denise_hamencoder
// Brief    : HAM6 encoder. Picks the closest decodable HAM code for each RGB
//            pixel from three modify codes and a local 16-entry palette copy.
//            Optional macro HAMENC_EARLY_EXIT_EN ends the search on an exact hit.
// Revision : 1.0 - initial release
// ============================================================================
module denise_hamencoder (
    input  logic        clk,
    input  logic        _reset,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [11:0] data_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_rgb,
    input  logic        in_sol,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_ham,
    output logic [5:0]  out_err
);

    localparam logic [8:0] COLORBASE = 9'h180;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_idx;
    logic [11:0] r_pix;
    logic [11:0] r_prev;
    logic [5:0]  r_best_code;
    logic [5:0]  r_best_err;
    logic [11:0] r_best_col;
    logic [11:0] r_palette [16];

    function automatic logic [5:0] abs_diff4(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? {2'b00, a - b} : {2'b00, b - a};
    endfunction

    function automatic logic [5:0] rgb_err(input logic [11:0] a, input logic [11:0] b);
        return abs_diff4(a[11:8], b[11:8]) + abs_diff4(a[7:4], b[7:4]) + abs_diff4(a[3:0], b[3:0]);
    endfunction

    // Palette shadow of COLOR00..COLOR15; writes land in any FSM state.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            for (int i = 0; i < 16; i++) begin
                r_palette[i] <= 12'h000;
            end
        end else if (clk7_en && (reg_address_in[8:5] == COLORBASE[8:5])) begin
            r_palette[reg_address_in[4:1]] <= data_in;
        end
    end

    logic [11:0] w_prev_eff;
    logic [11:0] w_mb_col;
    logic [11:0] w_mr_col;
    logic [11:0] w_mg_col;
    logic [5:0]  w_mb_err;
    logic [5:0]  w_mr_err;
    logic [5:0]  w_mg_err;
    logic [5:0]  w_mod_code;
    logic [5:0]  w_mod_err;
    logic [11:0] w_mod_col;

    assign w_prev_eff = in_sol ? r_palette[0] : r_prev;
    assign w_mb_col   = {w_prev_eff[11:4], in_rgb[3:0]};
    assign w_mr_col   = {in_rgb[11:8], w_prev_eff[7:0]};
    assign w_mg_col   = {w_prev_eff[11:8], in_rgb[7:4], w_prev_eff[3:0]};
    assign w_mb_err   = rgb_err(in_rgb, w_mb_col);
    assign w_mr_err   = rgb_err(in_rgb, w_mr_col);
    assign w_mg_err   = rgb_err(in_rgb, w_mg_col);

    // Ties keep the earlier candidate, so blue beats red beats green.
    always_comb begin
        w_mod_code = {2'b01, in_rgb[3:0]};
        w_mod_err  = w_mb_err;
        w_mod_col  = w_mb_col;
        if (w_mr_err < w_mod_err) begin
            w_mod_code = {2'b10, in_rgb[11:8]};
            w_mod_err  = w_mr_err;
            w_mod_col  = w_mr_col;
        end
        if (w_mg_err < w_mod_err) begin
            w_mod_code = {2'b11, in_rgb[7:4]};
            w_mod_err  = w_mg_err;
            w_mod_col  = w_mg_col;
        end
    end

    logic [11:0] w_pal_col;
    logic [5:0]  w_pal_err;
    logic        w_pal_better;

    assign w_pal_col    = r_palette[r_idx];
    assign w_pal_err    = rgb_err(r_pix, w_pal_col);
    assign w_pal_better = (w_pal_err < r_best_err);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef HAMENC_EARLY_EXIT_EN
                    if (w_mod_err == 6'd0) begin
                        w_next_state = S_EMIT;
                    end else begin
                        w_next_state = S_SEARCH;
                    end
`else
                    w_next_state = S_SEARCH;
`endif
                end
            end
            S_SEARCH: begin
`ifdef HAMENC_EARLY_EXIT_EN
                if ((w_pal_better && (w_pal_err == 6'd0)) || (r_idx == 4'd15)) begin
                    w_next_state = S_EMIT;
                end
`else
                if (r_idx == 4'd15) begin
                    w_next_state = S_EMIT;
                end
`endif
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_idx       <= 4'd0;
            r_pix       <= 12'h000;
            r_prev      <= 12'h000;
            r_best_code <= 6'h00;
            r_best_err  <= 6'h00;
            r_best_col  <= 12'h000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_pix       <= in_rgb;
                        r_idx       <= 4'd0;
                        r_best_code <= w_mod_code;
                        r_best_err  <= w_mod_err;
                        r_best_col  <= w_mod_col;
                    end
                end
                S_SEARCH: begin
                    if (w_pal_better) begin
                        r_best_code <= {2'b00, r_idx};
                        r_best_err  <= w_pal_err;
                        r_best_col  <= w_pal_col;
                    end
                    r_idx <= r_idx + 4'd1;
                end
                S_EMIT: begin
                    // The decoder's previous colour advances only when the code is taken.
                    if (out_ready) begin
                        r_prev <= r_best_col;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_EMIT);
    assign out_ham   = r_best_code;
    assign out_err   = r_best_err;

endmodule
`default_nettype wire

// File: tb/tb_denise_hamencoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_denise_hamencoder
// Brief    : Scoreboard bench for denise_hamencoder with directed pixel vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_denise_hamencoder;

    logic        clk = 1'b0;
    logic        _reset;
    logic        clk7_en;
    logic [8:1]  reg_address_in;
    logic [11:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_rgb;
    logic        in_sol;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_ham;
    logic [5:0]  out_err;

    denise_hamencoder dut (
        .clk            (clk),
        ._reset         (_reset),
        .clk7_en        (clk7_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rgb         (in_rgb),
        .in_sol         (in_sol),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ham        (out_ham),
        .out_err        (out_err)
    );

`ifdef HAMENC_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    always #5 clk = ~clk;

    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q [$];
    logic [11:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected {ham, err} per output handshake.
    always @(negedge clk) begin
        if (_reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard: unexpected code 0x%0h, expected none", out_ham);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_ham", {26'd0, out_ham}, {26'd0, mon_e[11:6]});
                check("out_err", {26'd0, out_err}, {26'd0, mon_e[5:0]});
            end
        end
    end

    task automatic write_reg(input logic [7:0] a, input logic [11:0] d, input logic en);
        reg_address_in = a;
        data_in        = d;
        clk7_en        = en;
        @(posedge clk); #1;
        clk7_en        = 1'b0;
    endtask

    task automatic send(input logic [11:0] rgb, input logic sol,
                        input logic [5:0] ham, input logic [5:0] err, input bit push);
        int n = 0;
        in_rgb   = rgb;
        in_sol   = sol;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        if (push) exp_q.push_back({ham, err});
    endtask

    task automatic wait_out(input string name, input int lat);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, cyc - acc_cyc, lat);
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        _reset         = 1'b0;
        clk7_en        = 1'b0;
        reg_address_in = 8'h00;
        data_in        = 12'h000;
        in_valid       = 1'b0;
        in_rgb         = 12'h000;
        in_sol         = 1'b0;
        out_ready      = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready",  {31'd0, in_ready}, 1);
        check("rst_out_ham",   {26'd0, out_ham}, 0);
        check("rst_out_err",   {26'd0, out_err}, 0);
        @(posedge clk); #1;
        _reset = 1'b1;
        @(posedge clk); #1;

        send(12'h000, 1'b1, 6'h10, 6'd0, 1'b1);
        wait_out("pix000", EE ? 0 : 16);

        write_reg(8'hC5, 12'h5A3, 1'b1);
        send(12'h5A3, 1'b1, 6'h05, 6'd0, 1'b1);
        wait_out("pix5a3", EE ? 6 : 16);
        send(12'h5A9, 1'b0, 6'h19, 6'd0, 1'b1);
        wait_out("pix5a9", EE ? 0 : 16);

        // Unqualified write must not reach the palette.
        write_reg(8'hC6, 12'h777, 1'b0);
        send(12'h777, 1'b1, 6'h05, 6'd9, 1'b1);
        wait_out("pix777", 16);

        out_ready = 1'b0;
        send(12'h0F0, 1'b1, 6'h3F, 6'd0, 1'b1);
        wait_out("pix0f0", EE ? 0 : 16);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", {31'd0, out_valid}, 1);
            check("stall_out_ham",   {26'd0, out_ham}, 32'h3F);
            check("stall_out_err",   {26'd0, out_err}, 0);
            check("stall_in_ready",  {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready",  {31'd0, in_ready}, 1);
        check("release_out_valid", {31'd0, out_valid}, 0);

        send(12'hABC, 1'b0, 6'h00, 6'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        _reset = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 0);
        check("abort_in_ready",  {31'd0, in_ready}, 1);
        check("abort_out_ham",   {26'd0, out_ham}, 0);
        repeat (2) @(posedge clk);
        #1;
        _reset = 1'b1;
        @(posedge clk); #1;

        send(12'h00F, 1'b1, 6'h1F, 6'd0, 1'b1);
        wait_out("pix00f", EE ? 0 : 16);

        send(12'h9C6, 1'b1, 6'h0F, 6'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        write_reg(8'hCF, 12'h9C6, 1'b1);
        wait_out("pix9c6", 16);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
